// File: rtl/lfsr_stream_checker_if.sv
// Stream and status bundle between an LFSR bit source and lfsr_stream_checker.
// q_in is taken on a rising clock edge only when in_valid=1 and resync=0; there is no ready, the checker always accepts.
interface lfsr_stream_checker_if #(
  parameter int CNT_W = 16
);
  logic             q_in;
  logic             in_valid;
  logic             resync;
  logic             clear;
  logic             locked;
  logic             bit_error;
  logic             stuck;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output q_in, in_valid, resync, clear,
    input  locked, bit_error, stuck, err_count, bit_count
  );

  modport slave (
    input  q_in, in_valid, resync, clear,
    output locked, bit_error, stuck, err_count, bit_count
  );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Self-synchronising LFSR stream checker: captures WIDTH bits as its shadow state, then
// predicts each following bit and reports lock, per-bit errors, saturating counts and stuck-at-zero.
module lfsr_stream_checker #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] TAPS        = 32'h80200003,
  parameter int               CNT_W       = 16,
  parameter int               LOSS_THRESH = 4
) (
  input  logic                 clock,
  input  logic                 rst,
  lfsr_stream_checker_if.slave bus,
  output logic                 dbg_state
);

  localparam int ACQ_W  = $clog2(WIDTH);
  localparam int MISS_W = 4;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  r, r_n;
  logic [ACQ_W-1:0]  acq_cnt, acq_n;
  logic [MISS_W-1:0] miss_cnt, miss_n;
  logic [CNT_W-1:0]  err_n, bits_n;
  logic              berr_n;
  logic              pred;

  assign dbg_state = (state == LOCKED);
  assign pred      = ^(r & TAPS);

  always_comb begin
    state_n = state;
    r_n     = r;
    acq_n   = acq_cnt;
    miss_n  = miss_cnt;
    err_n   = bus.err_count;
    bits_n  = bus.bit_count;
    berr_n  = 1'b0;
    if (bus.resync) begin
      state_n = ACQUIRE;
      acq_n   = '0;
      miss_n  = '0;
    end else if (bus.in_valid) begin
      case (state)
        ACQUIRE: begin
          r_n   = {r[WIDTH-2:0], bus.q_in};
          acq_n = acq_cnt + 1'b1;
          if (acq_cnt == ACQ_W'(WIDTH - 1)) begin
            state_n = LOCKED;
            acq_n   = '0;
          end
        end
        LOCKED: begin
          // Shift in the prediction so an isolated line error cannot corrupt the shadow state.
          r_n = {r[WIDTH-2:0], pred};
          if (bus.bit_count != '1) bits_n = bus.bit_count + 1'b1;
          if (bus.q_in != pred) begin
            berr_n = 1'b1;
            if (bus.err_count != '1) err_n = bus.err_count + 1'b1;
            if (miss_cnt == MISS_W'(LOSS_THRESH - 1)) begin
              state_n = ACQUIRE;
              acq_n   = '0;
              miss_n  = '0;
            end else begin
              miss_n = miss_cnt + 1'b1;
            end
          end else begin
            miss_n = '0;
          end
        end
        default: state_n = ACQUIRE;
      endcase
    end
    if (bus.clear) begin
      err_n  = '0;
      bits_n = '0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state         <= ACQUIRE;
      r             <= '0;
      acq_cnt       <= '0;
      miss_cnt      <= '0;
      bus.locked    <= 1'b0;
      bus.bit_error <= 1'b0;
      bus.stuck     <= 1'b0;
      bus.err_count <= '0;
      bus.bit_count <= '0;
    end else begin
      state         <= state_n;
      r             <= r_n;
      acq_cnt       <= acq_n;
      miss_cnt      <= miss_n;
      bus.locked    <= (state_n == LOCKED);
      bus.bit_error <= berr_n;
      bus.stuck     <= (state_n == LOCKED) && (r_n == '0);
      bus.err_count <= err_n;
      bus.bit_count <= bits_n;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: a 16-bit-counter instance plus a 4-bit-counter
// instance fed the same stream for saturation.
module tb_lfsr_stream_checker;
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] SEED = 32'h150F2464;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic dbg_state, dbg_state4;
  logic [31:0] gen;
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  lfsr_stream_checker_if #(.CNT_W(16)) bus  ();
  lfsr_stream_checker_if #(.CNT_W(4))  bus4 ();

  assign bus4.q_in     = bus.q_in;
  assign bus4.in_valid = bus.in_valid;
  assign bus4.resync   = bus.resync;
  assign bus4.clear    = bus.clear;

  lfsr_stream_checker #(.WIDTH(32), .TAPS(TAPS), .CNT_W(16), .LOSS_THRESH(4)) dut (
    .clock(clock), .rst(rst), .bus(bus.slave), .dbg_state(dbg_state)
  );

  lfsr_stream_checker #(.WIDTH(32), .TAPS(TAPS), .CNT_W(4), .LOSS_THRESH(4)) dut4 (
    .clock(clock), .rst(rst), .bus(bus4.slave), .dbg_state(dbg_state4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic b, input logic v, input logic rs, input logic cl);
    bus.q_in     = b;
    bus.in_valid = v;
    bus.resync   = rs;
    bus.clear    = cl;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.resync   = 1'b0;
    bus.clear    = 1'b0;
  endtask

  // Reference generator: q = s[31], next = {s[30:0], ^(s & TAPS)}; flip corrupts the sent bit only.
  task automatic send_gen(input logic flip);
    logic b;
    b   = gen[31];
    gen = {gen[30:0], ^(gen & TAPS)};
    cyc(b ^ flip, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic logic garbage();
    return 1'($urandom_range(0, 1));
  endfunction

  initial begin
    bus.q_in = 1'b0; bus.in_valid = 1'b0; bus.resync = 1'b0; bus.clear = 1'b0;
    gen = SEED;
    repeat (2) @(posedge clock);
    #1;
    check("rst_locked", {31'd0, bus.locked}, 32'd0);
    check("rst_bit_error", {31'd0, bus.bit_error}, 32'd0);
    check("rst_stuck", {31'd0, bus.stuck}, 32'd0);
    check("rst_err_count", {16'd0, bus.err_count}, 32'd0);
    check("rst_bit_count", {16'd0, bus.bit_count}, 32'd0);
    check("rst_err_count4", {28'd0, bus4.err_count}, 32'd0);
    rst = 1'b0;

    // 1: resync with a valid bit present must not sample it; lock after exactly 32 bits
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 31; i++) send_gen(1'b0);
    check("t1_locked_b31", {31'd0, bus.locked}, 32'd0);
    send_gen(1'b0);
    check("t1_locked_b32", {31'd0, bus.locked}, 32'd1);
    for (int i = 33; i <= 40; i++) begin
      send_gen(1'b0);
      check("t1_bit_error", {31'd0, bus.bit_error}, 32'd0);
    end
    check("t1_bit_count", {16'd0, bus.bit_count}, 32'd8);
    check("t1_err_count", {16'd0, bus.err_count}, 32'd0);
    check("t1_bit_count4", {28'd0, bus4.bit_count}, 32'd8);

    // 2: single flipped bit 50
    for (int i = 41; i <= 49; i++) send_gen(1'b0);
    send_gen(1'b1);
    check("t2_bit_error_b50", {31'd0, bus.bit_error}, 32'd1);
    check("t2_err_count_b50", {16'd0, bus.err_count}, 32'd1);
    check("t2_locked_b50", {31'd0, bus.locked}, 32'd1);
    send_gen(1'b0);
    check("t2_bit_error_b51", {31'd0, bus.bit_error}, 32'd0);
    for (int i = 52; i <= 55; i++) send_gen(1'b0);
    check("t2_err_count", {16'd0, bus.err_count}, 32'd1);
    check("t2_bit_count", {16'd0, bus.bit_count}, 32'd23);

    // 3: clear, then 4 consecutive errors drop lock; reacquire on 32 clean bits
    cyc(garbage(), 1'b0, 1'b0, 1'b1);
    check("t3_clear_err", {16'd0, bus.err_count}, 32'd0);
    check("t3_clear_bits", {16'd0, bus.bit_count}, 32'd0);
    check("t3_clear_locked", {31'd0, bus.locked}, 32'd1);
    for (int i = 1; i <= 3; i++) send_gen(1'b1);
    check("t3_locked_3miss", {31'd0, bus.locked}, 32'd1);
    send_gen(1'b1);
    check("t3_locked_4miss", {31'd0, bus.locked}, 32'd0);
    check("t3_err_count", {16'd0, bus.err_count}, 32'd4);
    check("t3_bit_count", {16'd0, bus.bit_count}, 32'd4);
    check("t3_bit_error", {31'd0, bus.bit_error}, 32'd1);
    for (int i = 1; i <= 31; i++) send_gen(1'b0);
    check("t3_relock_b31", {31'd0, bus.locked}, 32'd0);
    send_gen(1'b0);
    check("t3_relock_b32", {31'd0, bus.locked}, 32'd1);
    for (int i = 1; i <= 8; i++) send_gen(1'b0);
    check("t3_err_after", {16'd0, bus.err_count}, 32'd4);
    check("t3_bits_after", {16'd0, bus.bit_count}, 32'd12);
    check("t3_bit_error_after", {31'd0, bus.bit_error}, 32'd0);

    // 4: all-zero stream locks as stuck; resync releases
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_resync_locked", {31'd0, bus.locked}, 32'd0);
    for (int i = 1; i <= 32; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_locked", {31'd0, bus.locked}, 32'd1);
    check("t4_stuck", {31'd0, bus.stuck}, 32'd1);
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_stuck_hold", {31'd0, bus.stuck}, 32'd1);
    check("t4_err_count", {16'd0, bus.err_count}, 32'd4);
    check("t4_bit_count", {16'd0, bus.bit_count}, 32'd20);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_stuck_resync", {31'd0, bus.stuck}, 32'd0);
    check("t4_locked_resync", {31'd0, bus.locked}, 32'd0);

    // 5: valid on alternate cycles with garbage on idle cycles; clear mid-run
    gen = SEED;
    cyc(garbage(), 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      send_gen(1'b0);
      if (i == 31) check("t5_locked_v31", {31'd0, bus.locked}, 32'd0);
      if (i == 32) check("t5_locked_v32", {31'd0, bus.locked}, 32'd1);
      if (i == 48) begin
        check("t5_bits_v48", {16'd0, bus.bit_count}, 32'd16);
        cyc(garbage(), 1'b0, 1'b0, 1'b1);
        check("t5_clear_bits", {16'd0, bus.bit_count}, 32'd0);
        check("t5_clear_err", {16'd0, bus.err_count}, 32'd0);
        check("t5_clear_locked", {31'd0, bus.locked}, 32'd1);
      end else begin
        cyc(garbage(), 1'b0, 1'b0, 1'b0);
      end
    end
    check("t5_bit_count", {16'd0, bus.bit_count}, 32'd16);
    check("t5_err_count", {16'd0, bus.err_count}, 32'd0);
    check("t5_bit_error_idle", {31'd0, bus.bit_error}, 32'd0);
    check("t5_dbg_state", {31'd0, dbg_state}, 32'd1);

    // 6: 20 alternating errors saturate the 4-bit counters; async reset mid-lock
    cyc(garbage(), 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      send_gen(1'b1);
      send_gen(1'b0);
    end
    check("t6_err_count4_sat", {28'd0, bus4.err_count}, 32'd15);
    check("t6_bit_count4_sat", {28'd0, bus4.bit_count}, 32'd15);
    check("t6_err_count", {16'd0, bus.err_count}, 32'd20);
    check("t6_bit_count", {16'd0, bus.bit_count}, 32'd40);
    check("t6_locked", {31'd0, bus.locked}, 32'd1);
    rst = 1'b1;
    #2;
    check("t6_arst_locked", {31'd0, bus.locked}, 32'd0);
    check("t6_arst_err_count", {16'd0, bus.err_count}, 32'd0);
    check("t6_arst_bit_count", {16'd0, bus.bit_count}, 32'd0);
    check("t6_arst_err_count4", {28'd0, bus4.err_count}, 32'd0);
    check("t6_arst_dbg_state", {31'd0, dbg_state}, 32'd0);
    @(posedge clock);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) send_gen(1'b0);
    check("t6_reacq_b31", {31'd0, bus.locked}, 32'd0);
    send_gen(1'b0);
    check("t6_reacq_b32", {31'd0, bus.locked}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
